// File: rtl/ddr3_rd_arbiter_if.sv
// Bundle of per-channel AXI4 read requester signals and the single controller read port.
// The master modport is the arbiter's view; slave is the requesters/controller side.
interface ddr3_rd_arbiter_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDRS      = 27,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CH-1:0]          s_arvalid_i;
  logic [NUM_CH-1:0]          s_arready_o;
  logic [NUM_CH*ADDRS-1:0]    s_araddr_i;
  logic [NUM_CH*ID_WIDTH-1:0] s_arid_i;
  logic [NUM_CH*8-1:0]        s_arlen_i;
  logic [NUM_CH*2-1:0]        s_arburst_i;
  logic [NUM_CH-1:0]          s_rvalid_o;
  logic [NUM_CH-1:0]          s_rready_i;
  logic                       s_rlast_o;
  logic [1:0]                 s_rresp_o;
  logic [ID_WIDTH-1:0]        s_rid_o;
  logic [DATA_WIDTH-1:0]      s_rdata_o;

  logic                       m_arvalid_o;
  logic                       m_arready_i;
  logic [ADDRS-1:0]           m_araddr_o;
  logic [ID_WIDTH-1:0]        m_arid_o;
  logic [7:0]                 m_arlen_o;
  logic [1:0]                 m_arburst_o;
  logic                       m_rvalid_i;
  logic                       m_rready_o;
  logic                       m_rlast_i;
  logic [1:0]                 m_rresp_i;
  logic [ID_WIDTH-1:0]        m_rid_i;
  logic [DATA_WIDTH-1:0]      m_rdata_i;

  logic                       busy_o;
  logic                       error_o;

  modport master (
    input  s_arvalid_i, s_araddr_i, s_arid_i, s_arlen_i, s_arburst_i, s_rready_i,
    output s_arready_o, s_rvalid_o, s_rlast_o, s_rresp_o, s_rid_o, s_rdata_o,
    output m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o, m_rready_o,
    input  m_arready_i, m_rvalid_i, m_rlast_i, m_rresp_i, m_rid_i, m_rdata_i,
    output busy_o, error_o
  );

  modport slave (
    output s_arvalid_i, s_araddr_i, s_arid_i, s_arlen_i, s_arburst_i, s_rready_i,
    input  s_arready_o, s_rvalid_o, s_rlast_o, s_rresp_o, s_rid_o, s_rdata_o,
    input  m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o, m_rready_o,
    output m_arready_i, m_rvalid_i, m_rlast_i, m_rresp_i, m_rid_i, m_rdata_i,
    input  busy_o, error_o
  );
endinterface

// File: rtl/ddr3_rd_arbiter.sv
// N-channel AXI4 read arbiter in front of the DDR3 controller read port.
// R beats are steered back via an in-order route FIFO (controller returns bursts in issue order).
module ddr3_rd_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDRS       = 27,
  parameter int ID_WIDTH    = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int PENDING     = 4,
  parameter int ROUND_ROBIN = 1
) (
  input logic               clock,
  input logic               reset,
  ddr3_rd_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = (PENDING > 1) ? $clog2(PENDING) : 1;
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PENDING);

  logic [ADDRS-1:0]    addr_ch  [NUM_CH];
  logic [ID_WIDTH-1:0] id_ch    [NUM_CH];
  logic [7:0]          len_ch   [NUM_CH];
  logic [1:0]          burst_ch [NUM_CH];

  logic [PTR_W-1:0] rr_ptr, gnt_idx, head;
  logic             gnt_any, slot_free, capture, ne, push, pop, rready;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W-1:0] route_mem [PENDING];
  logic [NUM_CH-1:0] arready_v, rvalid_v;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign addr_ch[k]  = bus.s_araddr_i[k*ADDRS +: ADDRS];
    assign id_ch[k]    = bus.s_arid_i[k*ID_WIDTH +: ID_WIDTH];
    assign len_ch[k]   = bus.s_arlen_i[k*8 +: 8];
    assign burst_ch[k] = bus.s_arburst_i[k*2 +: 2];
  end

  // Round-robin starts the search just past the last winner; fixed priority starts at 0.
  always_comb begin
    logic [PTR_W-1:0] cand;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (ROUND_ROBIN != 0) ? PTR_W'((int'(rr_ptr) + 1 + i) % NUM_CH) : PTR_W'(i);
      if (!gnt_any && bus.s_arvalid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A pop in this cycle does not free a FIFO slot for a capture in the same cycle.
  assign slot_free = ~bus.m_arvalid_o | bus.m_arready_i;
  assign capture   = ~reset & slot_free & gnt_any & (cnt < FULL);
  assign push      = capture;
  assign ne        = (cnt != '0);
  assign head      = route_mem[rd_ptr];
  assign rready    = ne & bus.s_rready_i[head];
  assign pop       = bus.m_rvalid_i & rready & bus.m_rlast_i;

  always_comb begin
    arready_v = '0;
    rvalid_v  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arready_v[k] = capture & (gnt_idx == PTR_W'(k));
      rvalid_v[k]  = bus.m_rvalid_i & ne & (head == PTR_W'(k));
    end
  end

  assign bus.s_arready_o = arready_v;
  assign bus.s_rvalid_o  = rvalid_v;
  assign bus.m_rready_o  = rready;
  assign bus.s_rlast_o   = bus.m_rlast_i;
  assign bus.s_rresp_o   = bus.m_rresp_i;
  assign bus.s_rid_o     = bus.m_rid_i;
  assign bus.s_rdata_o   = bus.m_rdata_i;
  assign bus.busy_o      = bus.m_arvalid_o | ne;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.m_arvalid_o <= 1'b0;
      bus.m_araddr_o  <= '0;
      bus.m_arid_o    <= '0;
      bus.m_arlen_o   <= '0;
      bus.m_arburst_o <= '0;
      rr_ptr          <= PTR_W'(NUM_CH - 1);
    end else if (capture) begin
      bus.m_arvalid_o <= 1'b1;
      bus.m_araddr_o  <= addr_ch[gnt_idx];
      bus.m_arid_o    <= id_ch[gnt_idx];
      bus.m_arlen_o   <= len_ch[gnt_idx];
      bus.m_arburst_o <= burst_ch[gnt_idx];
      rr_ptr          <= gnt_idx;
    end else if (bus.m_arready_i) begin
      bus.m_arvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      bus.error_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.m_rvalid_i && !ne) bus.error_o <= 1'b1;
    end
  end

  // Route storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clock) begin
    if (push) route_mem[wr_ptr] <= gnt_idx;
  end
endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Directed bench: grant-order vector table on 4-channel RR/fixed instances, plus
// hand-written sequences on the default 2-channel instance.
module tb_ddr3_rd_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ddr3_rd_arbiter_if #(.NUM_CH(2)) i2  ();
  ddr3_rd_arbiter_if #(.NUM_CH(4)) i4r ();
  ddr3_rd_arbiter_if #(.NUM_CH(4)) i4f ();

  ddr3_rd_arbiter #(.NUM_CH(2)) d2 (.clock(clock), .reset(reset), .bus(i2.master));
  ddr3_rd_arbiter #(.NUM_CH(4), .PENDING(16), .ROUND_ROBIN(1)) d4r (.clock(clock), .reset(reset), .bus(i4r.master));
  ddr3_rd_arbiter #(.NUM_CH(4), .PENDING(16), .ROUND_ROBIN(0)) d4f (.clock(clock), .reset(reset), .bus(i4f.master));

  typedef struct {
    logic [3:0] arv;
    logic [3:0] exp_rr;
    logic [3:0] exp_fp;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    tv[0]  = '{4'b1111, 4'b0001, 4'b0001};
    tv[1]  = '{4'b1111, 4'b0010, 4'b0001};
    tv[2]  = '{4'b1111, 4'b0100, 4'b0001};
    tv[3]  = '{4'b1111, 4'b1000, 4'b0001};
    tv[4]  = '{4'b1111, 4'b0001, 4'b0001};
    tv[5]  = '{4'b1010, 4'b0010, 4'b0010};
    tv[6]  = '{4'b1010, 4'b1000, 4'b0010};
    tv[7]  = '{4'b0100, 4'b0100, 4'b0100};
    tv[8]  = '{4'b0000, 4'b0000, 4'b0000};
    tv[9]  = '{4'b1001, 4'b1000, 4'b0001};
    tv[10] = '{4'b1001, 4'b0001, 4'b0001};

    i2.s_arvalid_i = '0; i2.s_araddr_i = '0; i2.s_arid_i = '0; i2.s_arlen_i = '0;
    i2.s_arburst_i = '0; i2.s_rready_i = 2'b11; i2.m_arready_i = 1'b1; i2.m_rvalid_i = 1'b0;
    i2.m_rlast_i = 1'b0; i2.m_rresp_i = '0; i2.m_rid_i = '0; i2.m_rdata_i = '0;
    i4r.s_arvalid_i = '0; i4r.s_araddr_i = '0; i4r.s_arid_i = {4'd4, 4'd3, 4'd2, 4'd1};
    i4r.s_arlen_i = '0; i4r.s_arburst_i = '0; i4r.s_rready_i = '1; i4r.m_arready_i = 1'b1;
    i4r.m_rvalid_i = 1'b0; i4r.m_rlast_i = 1'b0; i4r.m_rresp_i = '0; i4r.m_rid_i = '0; i4r.m_rdata_i = '0;
    i4f.s_arvalid_i = '0; i4f.s_araddr_i = '0; i4f.s_arid_i = {4'd4, 4'd3, 4'd2, 4'd1};
    i4f.s_arlen_i = '0; i4f.s_arburst_i = '0; i4f.s_rready_i = '1; i4f.m_arready_i = 1'b1;
    i4f.m_rvalid_i = 1'b0; i4f.m_rlast_i = 1'b0; i4f.m_rresp_i = '0; i4f.m_rid_i = '0; i4f.m_rdata_i = '0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_arvalid", i2.m_arvalid_o, 0);
    chk("rst_arready", i2.s_arready_o, 0);
    chk("rst_busy", i2.busy_o, 0);
    chk("rst_error", i2.error_o, 0);
    chk("rst_rready", i2.m_rready_o, 0);

    // Grant order on 4-channel round-robin and fixed-priority instances
    for (int v = 0; v < 11; v++) begin
      @(negedge clock);
      i4r.s_arvalid_i = tv[v].arv;
      i4f.s_arvalid_i = tv[v].arv;
      #1;
      chk($sformatf("rr_gnt[%0d]", v), i4r.s_arready_o, tv[v].exp_rr);
      chk($sformatf("fp_gnt[%0d]", v), i4f.s_arready_o, tv[v].exp_fp);
      @(posedge clock); #1;
      chk($sformatf("rr_vld[%0d]", v), i4r.m_arvalid_o, |tv[v].exp_rr);
      if (tv[v].exp_rr != 0)
        chk($sformatf("rr_id[%0d]", v), i4r.m_arid_o, oh2i(tv[v].exp_rr) + 1);
      if (tv[v].exp_fp != 0)
        chk($sformatf("fp_id[%0d]", v), i4f.m_arid_o, oh2i(tv[v].exp_fp) + 1);
    end
    @(negedge clock);
    i4r.s_arvalid_i = '0;
    i4f.s_arvalid_i = '0;

    // Single burst from channel 1, 4 beats routed back to channel 1 only
    @(negedge clock);
    i2.s_araddr_i = {27'h0, 27'h000100} << 27;
    i2.s_arlen_i  = {8'd3, 8'd0};
    i2.s_arid_i   = {4'h5, 4'h0};
    i2.s_arvalid_i = 2'b10;
    #1 chk("t1_arready", i2.s_arready_o, 2'b10);
    @(posedge clock); #1;
    chk("t1_arvalid", i2.m_arvalid_o, 1);
    chk("t1_araddr", i2.m_araddr_o, 27'h000100);
    chk("t1_arlen", i2.m_arlen_o, 3);
    chk("t1_arid", i2.m_arid_o, 5);
    chk("t1_busy", i2.busy_o, 1);
    i2.s_arvalid_i = 2'b00;
    #1 chk("t1_arready_off", i2.s_arready_o, 0);
    @(posedge clock); #1;
    chk("t1_hs_clear", i2.m_arvalid_o, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      i2.m_rvalid_i = 1'b1;
      i2.m_rdata_i  = 32'hA0 + b;
      i2.m_rlast_i  = (b == 3);
      #1;
      chk($sformatf("t1_rvalid[%0d]", b), i2.s_rvalid_o, 2'b10);
      chk($sformatf("t1_rready[%0d]", b), i2.m_rready_o, 1);
      chk($sformatf("t1_rdata[%0d]", b), i2.s_rdata_o, 32'hA0 + b);
    end
    @(negedge clock);
    i2.m_rvalid_i = 1'b0; i2.m_rlast_i = 1'b0;
    #1 chk("t1_busy_done", i2.busy_o, 0);

    // Fill the route FIFO, then show the pop cycle gives no capture credit
    i2.s_araddr_i = {27'h0, 27'h000200};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      i2.s_arvalid_i = 2'b01;
      #1 chk($sformatf("pend_acc[%0d]", i), i2.s_arready_o, 2'b01);
    end
    repeat (2) begin
      @(negedge clock); #1;
      chk("pend_full", i2.s_arready_o, 2'b00);
    end
    @(negedge clock);
    i2.m_rvalid_i = 1'b1; i2.m_rlast_i = 1'b1;
    #1;
    chk("pend_pop_rready", i2.m_rready_o, 1);
    chk("pend_pop_rvalid", i2.s_rvalid_o, 2'b01);
    chk("pend_no_credit", i2.s_arready_o, 2'b00);
    @(negedge clock);
    i2.m_rvalid_i = 1'b0; i2.m_rlast_i = 1'b0;
    #1 chk("pend_after_pop", i2.s_arready_o, 2'b01);
    @(posedge clock); #1;
    i2.s_arvalid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      i2.m_rvalid_i = 1'b1; i2.m_rlast_i = 1'b1;
      #1 chk($sformatf("pend_drain[%0d]", i), i2.s_rvalid_o, 2'b01);
    end
    @(negedge clock);
    i2.m_rvalid_i = 1'b0; i2.m_rlast_i = 1'b0;
    #1 chk("pend_busy_done", i2.busy_o, 0);

    // Controller stalls AR for 5 cycles; then back-to-back issue
    @(negedge clock);
    i2.m_arready_i = 1'b0;
    i2.s_araddr_i  = {27'h0AAAA, 27'h05555};
    i2.s_arvalid_i = 2'b10;
    #1 chk("stl_first", i2.s_arready_o, 2'b10);
    @(posedge clock); #1;
    i2.s_arvalid_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk($sformatf("stl_arready[%0d]", i), i2.s_arready_o, 2'b00);
      chk($sformatf("stl_addr[%0d]", i), i2.m_araddr_o, 27'h0AAAA);
      chk($sformatf("stl_vld[%0d]", i), i2.m_arvalid_o, 1);
    end
    @(negedge clock);
    i2.m_arready_i = 1'b1;
    #1 chk("stl_release", i2.s_arready_o, 2'b01);
    @(posedge clock); #1;
    chk("stl_b2b_addr", i2.m_araddr_o, 27'h05555);
    chk("stl_b2b_vld", i2.m_arvalid_o, 1);
    i2.s_arvalid_i = 2'b00;
    @(posedge clock); #1;
    chk("stl_vld_clr", i2.m_arvalid_o, 0);

    // Head channel not ready blocks all R traffic
    @(negedge clock);
    i2.m_rvalid_i = 1'b1; i2.m_rlast_i = 1'b1; i2.s_rready_i = 2'b01;
    #1;
    chk("hd_stall_rvalid", i2.s_rvalid_o, 2'b10);
    chk("hd_stall_rready", i2.m_rready_o, 0);
    @(negedge clock);
    i2.s_rready_i = 2'b11;
    #1 chk("hd_go_rready", i2.m_rready_o, 1);
    @(negedge clock); #1;
    chk("hd_second", i2.s_rvalid_o, 2'b01);
    @(negedge clock);
    i2.m_rvalid_i = 1'b0; i2.m_rlast_i = 1'b0;
    #1 chk("hd_busy_done", i2.busy_o, 0);

    // Orphan R beat
    @(negedge clock);
    i2.m_rvalid_i = 1'b1;
    #1;
    chk("err_rready", i2.m_rready_o, 0);
    chk("err_rvalid", i2.s_rvalid_o, 0);
    chk("err_pre", i2.error_o, 0);
    @(posedge clock); #1;
    chk("err_set", i2.error_o, 1);
    @(negedge clock);
    i2.m_rvalid_i = 1'b0;
    @(posedge clock); #1;
    chk("err_sticky", i2.error_o, 1);

    // Async reset in the middle of a burst
    @(negedge clock);
    i2.s_arvalid_i = 2'b10;
    @(posedge clock); #1;
    i2.s_arvalid_i = 2'b00;
    @(negedge clock);
    i2.m_rvalid_i = 1'b1;
    #1 chk("mid_rvalid", i2.s_rvalid_o, 2'b10);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_arvalid", i2.m_arvalid_o, 0);
    chk("mid_rst_busy", i2.busy_o, 0);
    chk("mid_rst_error", i2.error_o, 0);
    chk("mid_rst_rvalid", i2.s_rvalid_o, 0);
    chk("mid_rst_rready", i2.m_rready_o, 0);
    @(negedge clock);
    i2.m_rvalid_i = 1'b0;
    i2.s_arvalid_i = 2'b11;
    #1 chk("mid_rst_arready", i2.s_arready_o, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("mid_ch0_first", i2.s_arready_o, 2'b01);
    @(negedge clock);
    i2.s_arvalid_i = 2'b00;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
